// File: rtl/xrv_pkg.sv
// xrv_pkg: shared state enum, counter widths and sizing helper for the pipeline controller.
package xrv_pkg;
  localparam int LS_W = 4;
  localparam int FC_W = 3;
  typedef enum logic {RUN, FLUSH} pstate_t;
  function automatic int src_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/xrv_pipe_ctrl_if.sv
// xrv_pipe_ctrl_if: control bus between the core stages (master) and xrv_pipe_ctrl (slave).
interface xrv_pipe_ctrl_if #(
  parameter int XLEN = 32,
  parameter int NUM_JMP = 2,
  parameter int NUM_STALL = 1
);
  localparam int SW = xrv_pkg::src_w(NUM_JMP);
  logic [NUM_JMP-1:0] jmp_req;
  logic [NUM_JMP-1:0][XLEN-1:0] jmp_addr_in;
  logic ls_issue;
  logic ls_done;
  logic ls_fence;
  logic [NUM_STALL-1:0] stall_req;
  logic stalling;
  logic flush;
  logic jmp;
  logic [XLEN-1:0] jmp_addr;
  logic [SW-1:0] jmp_src;
  logic [xrv_pkg::LS_W-1:0] ls_cnt;
  logic ls_err;
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_evt;
  modport master (
    output jmp_req, jmp_addr_in, ls_issue, ls_done, ls_fence, stall_req,
    input stalling, flush, jmp, jmp_addr, jmp_src, ls_cnt, ls_err, perf_stall_cyc, perf_flush_evt
  );
  modport slave (
    input jmp_req, jmp_addr_in, ls_issue, ls_done, ls_fence, stall_req,
    output stalling, flush, jmp, jmp_addr, jmp_src, ls_cnt, ls_err, perf_stall_cyc, perf_flush_evt
  );
endinterface

// File: rtl/xrv_jmp_arb.sv
// xrv_jmp_arb: fixed-priority jump selector, lowest asserted index wins, purely combinational.
module xrv_jmp_arb #(
  parameter int NUM_JMP = 2,
  parameter int XLEN = 32,
  localparam int SW = xrv_pkg::src_w(NUM_JMP)
) (
  input  logic [NUM_JMP-1:0] req,
  input  logic [NUM_JMP-1:0][XLEN-1:0] addr_in,
  output logic jmp,
  output logic [XLEN-1:0] addr,
  output logic [SW-1:0] src
);
  assign jmp = |req;
  always_comb begin
    addr = '0;
    src = '0;
    for (int i = NUM_JMP - 1; i >= 0; i--)
      if (req[i]) begin
        addr = addr_in[i];
        src = SW'(i);
      end
  end
endmodule

// File: rtl/xrv_pipe_ctrl.sv
// xrv_pipe_ctrl: pipeline stall/flush/redirect control with outstanding load/store tracking.
// Define XRV_PIPE_CTRL_PERF_EN to build the stall-cycle and flush-event counters.
module xrv_pipe_ctrl
  import xrv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_JMP = 2,
  parameter int NUM_STALL = 1,
  parameter int LS_MAX = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input logic clk,
  input logic rstb,
  xrv_pipe_ctrl_if.slave bus
);
  localparam logic [LS_W-1:0] LSM = LS_W'(LS_MAX);
  localparam logic [LS_W:0] PMAX = (LS_W + 1)'(LS_MAX);
  localparam logic [FC_W-1:0] FCR = FC_W'(FLUSH_CYCLES - 1);
  localparam logic MULTI = FLUSH_CYCLES > 1;
  logic issue_ok, up, dn, full, empty;
  logic [NUM_STALL-1:0] stall_v;
  logic [LS_W:0] pend;
  logic [LS_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  pstate_t st_q, st_d;
  logic [FC_W-1:0] fc_q, fc_d;
  xrv_jmp_arb #(.NUM_JMP(NUM_JMP), .XLEN(XLEN)) u_arb (
    .req(bus.jmp_req),
    .addr_in(bus.jmp_addr_in),
    .jmp(bus.jmp),
    .addr(bus.jmp_addr),
    .src(bus.jmp_src)
  );
  // an issue in the redirect cycle belongs to a squashed instruction
  assign issue_ok = bus.ls_issue & ~bus.jmp;
  assign up = issue_ok & ~bus.ls_done;
  assign dn = bus.ls_done & ~issue_ok;
  assign full = cnt_q == LSM;
  assign empty = cnt_q == '0;
  assign pend = {1'b0, cnt_q} + {{LS_W{1'b0}}, issue_ok};
  assign stall_v = bus.stall_req;
  assign bus.stalling = (|stall_v) | ((pend >= PMAX) & ~bus.ls_done)
                      | (bus.ls_fence & (pend != '0) & ~((pend == (LS_W + 1)'(1)) & bus.ls_done));
  always_comb begin
    cnt_d = up ? (full ? cnt_q : cnt_q + 1'b1) : dn ? (empty ? cnt_q : cnt_q - 1'b1) : cnt_q;
    err_d = err_q | (up & full) | (dn & empty);
  end
  always_comb begin
    st_d = (bus.jmp & MULTI) ? FLUSH : (st_q == FLUSH && fc_q == FC_W'(1)) ? RUN : st_q;
    fc_d = (bus.jmp & MULTI) ? FCR : (st_q == FLUSH) ? fc_q - 1'b1 : fc_q;
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      st_q <= RUN;
      fc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      fc_q <= fc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign bus.flush = bus.jmp | (st_q == FLUSH);
  assign bus.ls_cnt = cnt_q;
  assign bus.ls_err = err_q;
`ifdef XRV_PIPE_CTRL_PERF_EN
  logic [31:0] pst_q, pfl_q;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      pst_q <= '0;
      pfl_q <= '0;
    end else begin
      pst_q <= pst_q + {31'd0, bus.stalling};
      pfl_q <= pfl_q + {31'd0, bus.jmp};
    end
  assign bus.perf_stall_cyc = pst_q;
  assign bus.perf_flush_evt = pfl_q;
`else
  assign bus.perf_stall_cyc = '0;
  assign bus.perf_flush_evt = '0;
`endif
endmodule

// File: tb/tb_xrv_pipe_ctrl.sv
// tb_xrv_pipe_ctrl: directed + random stimulus on two controller configurations against a behavioural model.
module tb_xrv_pipe_ctrl;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic [1:0] req = '0;
  logic [1:0][31:0] addr = '0;
  logic iss = 1'b0, dn = 1'b0, fen = 1'b0, st = 1'b0;
  int nchk = 0, nerr = 0;
  int cnt[2], rem[2], pst[2], pfl[2];
  bit err[2];
  int lsm[2] = '{2, 1};
  int fcy[2] = '{3, 1};
  always #5 clk = ~clk;
  xrv_pipe_ctrl_if #(.XLEN(32), .NUM_JMP(2), .NUM_STALL(1)) ifa (), ifb ();
  assign ifa.jmp_req = req;
  assign ifa.jmp_addr_in = addr;
  assign ifa.ls_issue = iss;
  assign ifa.ls_done = dn;
  assign ifa.ls_fence = fen;
  assign ifa.stall_req = st;
  assign ifb.jmp_req = req;
  assign ifb.jmp_addr_in = addr;
  assign ifb.ls_issue = iss;
  assign ifb.ls_done = dn;
  assign ifb.ls_fence = fen;
  assign ifb.stall_req = st;
  xrv_pipe_ctrl #(.XLEN(32), .NUM_JMP(2), .NUM_STALL(1), .LS_MAX(2), .FLUSH_CYCLES(3)) u_a (
    .clk(clk), .rstb(rstb), .bus(ifa.slave));
  xrv_pipe_ctrl #(.XLEN(32), .NUM_JMP(2), .NUM_STALL(1), .LS_MAX(1), .FLUSH_CYCLES(1)) u_b (
    .clk(clk), .rstb(rstb), .bus(ifb.slave));

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; rem[k] = 0; pst[k] = 0; pfl[k] = 0; err[k] = 1'b0;
    end
  endtask

  task automatic model(input int k, input logic stl, input logic fl, input logic j,
                       input logic [31:0] ja, input logic js, input logic [3:0] c,
                       input logic e, input logic [31:0] ps, input logic [31:0] pf);
    int ok, pend, n;
    bit jx, sx;
    logic [31:0] ax;
    jx = req != 2'b00;
    ax = req[0] ? addr[0] : req[1] ? addr[1] : 32'h0;
    ok = (iss && !jx) ? 1 : 0;
    pend = cnt[k] + ok;
    sx = st || (pend >= lsm[k] && !dn) || (fen && pend != 0 && !(pend == 1 && dn));
    chk("jmp", k, 32'(j), 32'(jx));
    chk("jmp_addr", k, ja, ax);
    chk("jmp_src", k, 32'(js), 32'(!req[0] && req[1]));
    chk("flush", k, 32'(fl), 32'(jx || rem[k] > 0));
    chk("stalling", k, 32'(stl), 32'(sx));
    chk("ls_cnt", k, 32'(c), 32'(cnt[k]));
    chk("ls_err", k, 32'(e), 32'(err[k]));
`ifdef XRV_PIPE_CTRL_PERF_EN
    chk("perf_stall_cyc", k, ps, 32'(pst[k]));
    chk("perf_flush_evt", k, pf, 32'(pfl[k]));
`else
    chk("perf_stall_cyc", k, ps, 32'h0);
    chk("perf_flush_evt", k, pf, 32'h0);
`endif
    n = cnt[k] + ok - int'(dn);
    if (n > lsm[k]) begin err[k] = 1'b1; n = lsm[k]; end
    if (n < 0) begin err[k] = 1'b1; n = 0; end
    cnt[k] = n;
    rem[k] = jx ? fcy[k] - 1 : (rem[k] > 0 ? rem[k] - 1 : 0);
    pst[k] += int'(sx);
    pfl[k] += int'(jx);
  endtask

  task automatic step(input logic [1:0] r, input logic i, input logic d, input logic f, input logic s);
    req = r; iss = i; dn = d; fen = f; st = s;
    #1;
    model(0, ifa.stalling, ifa.flush, ifa.jmp, ifa.jmp_addr, ifa.jmp_src, ifa.ls_cnt, ifa.ls_err,
          ifa.perf_stall_cyc, ifa.perf_flush_evt);
    model(1, ifb.stalling, ifb.flush, ifb.jmp, ifb.jmp_addr, ifb.jmp_src, ifb.ls_cnt, ifb.ls_err,
          ifb.perf_stall_cyc, ifb.perf_flush_evt);
    @(negedge clk);
  endtask

  task automatic rand_steps(input int num);
    for (int n = 0; n < num; n++) begin
      addr[0] = $urandom;
      addr[1] = $urandom;
      step(($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    addr[0] = 32'h100;
    addr[1] = 32'h200;
    reset_model();
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    step(2'b00, 0, 0, 0, 0);
    step(2'b11, 1, 0, 0, 0);
    step(2'b10, 0, 0, 0, 0);
    repeat (4) step(2'b00, 0, 0, 0, 0);
    step(2'b00, 1, 0, 0, 0);
    step(2'b00, 1, 0, 0, 0);
    step(2'b00, 0, 1, 0, 0);
    step(2'b00, 1, 1, 0, 0);
    step(2'b00, 0, 1, 0, 0);
    step(2'b00, 0, 1, 0, 0);
    step(2'b00, 1, 0, 1, 0);
    step(2'b00, 0, 0, 1, 0);
    step(2'b00, 0, 1, 1, 0);
    repeat (5) step(2'b00, 0, 0, 0, 1);
    step(2'b00, 0, 0, 0, 0);
    rand_steps(400);
    step(2'b01, 0, 0, 0, 0);
    step(2'b00, 1, 0, 0, 0);
    req = 2'b00; iss = 1'b0; dn = 1'b0; fen = 1'b0; st = 1'b0;
    #2 rstb = 1'b0;
    #1;
    chk("async_rst_cnt", 0, 32'(ifa.ls_cnt), 32'h0);
    chk("async_rst_flush", 0, 32'(ifa.flush), 32'h0);
    chk("async_rst_err", 1, 32'(ifb.ls_err), 32'h0);
    reset_model();
    @(negedge clk);
    rstb = 1'b1;
    rand_steps(100);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
